// File: rtl/tile_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tile_cursor_ctrl
//
// Front end of the minesweeper processor wrapper. Five raw pushbuttons are
// synchronised and debounced. Their rising edges move a wrapping tile cursor
// or request a reveal ("flip") of the tile under the cursor.
//
// Ports
//   clock      : system clock
//   reset      : asynchronous, active-low reset
//   btn_up     : raw button, asynchronous, active-high (row - 1, wraps)
//   btn_down   : raw button (row + 1, wraps)
//   btn_left   : raw button (col - 1, wraps)
//   btn_right  : raw button (col + 1, wraps)
//   btn_click  : raw button (reveal request)
//   x_topleft  : registered pixel x of the selected tile's top-left corner
//   y_topleft  : registered pixel y of the selected tile's top-left corner
//   VGAid      : registered linear tile index row*COLS+col, zero-extended
//   flip       : reveal request, high for FLIP_CYCLES cycles per click
// -----------------------------------------------------------------------------
module tile_cursor_ctrl #(
  parameter int COLS            = 10,
  parameter int ROWS            = 8,
  parameter int TILE_W          = 32,
  parameter int TILE_H          = 32,
  parameter int ORIGIN_X        = 160,
  parameter int ORIGIN_Y        = 112,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FLIP_CYCLES     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_click,
  output logic [9:0]  x_topleft,
  output logic [8:0]  y_topleft,
  output logic [31:0] VGAid,
  output logic        flip
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int NBTN      = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CLICK = 4;

  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW  = $clog2(FLIP_CYCLES + 1);

  localparam logic [CW-1:0]  COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0]  ROW_MAX   = RW'(ROWS - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0]  FLIP_LAST = FW'(FLIP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLIP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: synchroniser -> debouncer -> rising-edge detector
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] press;    // one-cycle pulse on a debounced 0->1 edge
  logic            db_click; // debounced click level, used to leave HOLD

  assign raw = {btn_click, btn_right, btn_left, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic           sync1;
      logic           sync2;
      logic           db;
      logic           db_prev;
      logic [DBW-1:0] cnt;

      // The counter only advances while the synchronised level disagrees
      // with the accepted level. Any agreement restarts it, so a glitch
      // shorter than DEBOUNCE_CYCLES samples can never be accepted.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1   <= 1'b0;
          sync2   <= 1'b0;
          db      <= 1'b0;
          db_prev <= 1'b0;
          cnt     <= '0;
        end else begin
          sync1   <= raw[gi];
          sync2   <= sync1;
          db_prev <= db;
          if (sync2 == db) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            db  <= sync2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign press[gi] = db & ~db_prev;
    end
  endgenerate

  assign db_click = g_btn[BTN_CLICK].db;

  // ---------------------------------------------------------------------------
  // Cursor next-state
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [FW-1:0] flip_cnt;
  logic [CW-1:0] col;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row;
  logic [RW-1:0] row_next;
  logic          move_ok;
  logic          go_right;
  logic          go_left;
  logic          go_down;
  logic          go_up;

  // Opposing presses in the same cycle cancel each other. A click in the
  // same cycle as a move takes priority, so the move is dropped.
  assign go_right = press[BTN_RIGHT] & ~press[BTN_LEFT];
  assign go_left  = press[BTN_LEFT]  & ~press[BTN_RIGHT];
  assign go_down  = press[BTN_DOWN]  & ~press[BTN_UP];
  assign go_up    = press[BTN_UP]    & ~press[BTN_DOWN];
  assign move_ok  = (state == S_IDLE) && !press[BTN_CLICK];

  always_comb begin
    col_next = col;
    if (move_ok && go_right) begin
      col_next = (col == COL_MAX) ? '0 : col + 1'b1;
    end else if (move_ok && go_left) begin
      col_next = (col == '0) ? COL_MAX : col - 1'b1;
    end
  end

  always_comb begin
    row_next = row;
    if (move_ok && go_down) begin
      row_next = (row == ROW_MAX) ? '0 : row + 1'b1;
    end else if (move_ok && go_up) begin
      row_next = (row == '0) ? ROW_MAX : row - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cursor registers and reveal FSM
  // ---------------------------------------------------------------------------
  // HOLD waits for the click to be released so that one long press
  // produces exactly one reveal request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      flip     <= 1'b0;
      flip_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      col <= col_next;
      row <= row_next;
      case (state)
        S_IDLE: begin
          if (press[BTN_CLICK]) begin
            state    <= S_FLIP;
            flip     <= 1'b1;
            flip_cnt <= '0;
          end
        end
        S_FLIP: begin
          if (flip_cnt == FLIP_LAST) begin
            state <= S_HOLD;
            flip  <= 1'b0;
          end else begin
            flip_cnt <= flip_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!db_click) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          flip  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered screen outputs
  // ---------------------------------------------------------------------------
  // Computing modulo the port width gives the same bits as computing wide and
  // truncating. Because the outputs are registered from col/row, they trail
  // a move by one cycle and stay constant while col/row are frozen.
  logic [9:0]  x_calc;
  logic [8:0]  y_calc;
  logic [31:0] id_calc;

  assign x_calc  = 10'(ORIGIN_X) + 10'(col) * 10'(TILE_W);
  assign y_calc  = 9'(ORIGIN_Y) + 9'(row) * 9'(TILE_H);
  assign id_calc = 32'(row) * 32'(COLS) + 32'(col);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_topleft <= 10'(ORIGIN_X);
      y_topleft <= 9'(ORIGIN_Y);
      VGAid     <= '0;
    end else begin
      x_topleft <= x_calc;
      y_topleft <= y_calc;
      VGAid     <= id_calc;
    end
  end

endmodule

// File: tb/tb_tile_cursor_ctrl.sv
`timescale 1ns/1ps
module tb_tile_cursor_ctrl;

  localparam int COLS = 10;
  localparam int ROWS = 8;
  localparam int TW   = 32;
  localparam int TH   = 32;
  localparam int OX   = 160;
  localparam int OY   = 112;
  localparam int DB   = 4;
  localparam int FC   = 4;

  localparam logic [4:0] M_UP    = 5'b00001;
  localparam logic [4:0] M_DOWN  = 5'b00010;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_CLICK = 5'b10000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic        btn_right = 1'b0, btn_click = 1'b0;
  logic [9:0]  x_topleft;
  logic [8:0]  y_topleft;
  logic [31:0] VGAid;
  logic        flip;

  tile_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .TILE_W(TW), .TILE_H(TH),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .DEBOUNCE_CYCLES(DB), .FLIP_CYCLES(FC)
  ) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_click(btn_click),
    .x_topleft(x_topleft), .y_topleft(y_topleft), .VGAid(VGAid), .flip(flip)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected observable events: a cursor move (new tile) or a flip pulse.
  typedef struct {
    bit is_flip;
    int col;
    int row;
    int start;
  } exp_t;

  exp_t q[$];
  int   m_col = 0;
  int   m_row = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
  endtask

  task automatic drive(input logic [4:0] m);
    btn_up    = m[0];
    btn_down  = m[1];
    btn_left  = m[2];
    btn_right = m[3];
    btn_click = m[4];
  endtask

  // Reference model: an accepted press (all buttons in the mask rise together)
  // either requests a flip of the current tile or moves the cursor on a torus.
  task automatic model_event(input logic [4:0] m, input int start);
    exp_t e;
    int   dc, dr;
    if (m[4]) begin
      e = '{1'b1, m_col, m_row, start};
      q.push_back(e);
    end else begin
      dc = int'(m[3]) - int'(m[2]);
      dr = int'(m[1]) - int'(m[0]);
      if (dc != 0 || dr != 0) begin
        m_col = (m_col + dc + COLS) % COLS;
        m_row = (m_row + dr + ROWS) % ROWS;
        e = '{1'b0, m_col, m_row, start};
        q.push_back(e);
      end
    end
  endtask

  // Hold the buttons in m for len cycles, then leave a quiet gap.
  // Lengths below DB must be rejected; DB+2 and above must be accepted.
  task automatic press(input logic [4:0] m, input int len);
    @(negedge clock);
    if (len >= DB + 2) model_event(m, cyc);
    $display("press mask=%b len=%0d -> expect tile (%0d,%0d)", m, len, m_col, m_row);
    drive(m);
    repeat (len) @(negedge clock);
    drive(5'b0);
    repeat (25) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    m_col = 0;
    m_row = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  // Monitor: any change of the tile outputs or a rising flip pops the next
  // expected event and compares it; pulse width and freezing are checked too.
  initial begin : monitor
    logic [9:0]  px;
    logic [8:0]  py;
    logic [31:0] pid;
    logic [31:0] fid;
    logic        pflip;
    int          flen;
    exp_t        e;
    px = 10'(OX); py = 9'(OY); pid = '0; fid = '0; pflip = 1'b0; flen = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        px = 10'(OX); py = 9'(OY); pid = '0; pflip = 1'b0; flen = 0;
      end else begin
        if (x_topleft !== px || y_topleft !== py || VGAid !== pid) begin
          chk("no_move_while_flip", 32'(pflip), 0);
          if (q.size() == 0 || q[0].is_flip) begin
            n_chk++;
            $display("FAIL unexpected_move: got x=%0d y=%0d id=%0d, required x=%0d y=%0d id=%0d (cycle %0d)",
                     x_topleft, y_topleft, VGAid, px, py, pid, cyc);
          end else begin
            e = q.pop_front();
            $display("move seen: id=%0d x=%0d y=%0d", VGAid, x_topleft, y_topleft);
            chk("move_x", 32'(x_topleft), OX + e.col * TW);
            chk("move_y", 32'(y_topleft), OY + e.row * TH);
            chk("move_id", VGAid, e.row * COLS + e.col);
            chk_rng("move_latency", cyc - e.start, DB + 3, DB + 5);
          end
          px = x_topleft; py = y_topleft; pid = VGAid;
        end
        if (flip && !pflip) begin
          if (q.size() == 0 || !q[0].is_flip) begin
            n_chk++;
            $display("FAIL unexpected_flip: got flip=1 id=%0d, required flip=0 (cycle %0d)", VGAid, cyc);
          end else begin
            e = q.pop_front();
            $display("flip seen: id=%0d", VGAid);
            chk("flip_id", VGAid, e.row * COLS + e.col);
            chk("flip_x", 32'(x_topleft), OX + e.col * TW);
            chk_rng("flip_latency", cyc - e.start, DB + 2, DB + 4);
          end
          flen = 1;
          fid  = VGAid;
        end else if (flip && pflip) begin
          flen++;
          chk("id_frozen_in_flip", VGAid, fid);
        end else if (!flip && pflip) begin
          chk("flip_width", flen, FC);
        end
        pflip = flip;
      end
    end
  end

  initial begin : stimulus
    drive(5'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_flip_low", 32'(flip), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_x", 32'(x_topleft), 160);
    chk("rst_y", 32'(y_topleft), 112);
    chk("rst_id", VGAid, 0);
    chk("rst_flip", 32'(flip), 0);
    repeat (50) @(negedge clock);

    // Debounce threshold
    press(M_RIGHT, 2);
    chk("short_press_ignored", VGAid, 0);
    press(M_RIGHT, 8);
    chk("right_id", VGAid, 1);
    chk("right_x", 32'(x_topleft), 192);

    // Wrap-around in both axes
    press(M_LEFT, 8);
    press(M_LEFT, 8);
    chk("left_wrap_id", VGAid, 9);
    chk("left_wrap_x", 32'(x_topleft), 448);
    press(M_UP, 8);
    chk("up_wrap_id", VGAid, 79);
    chk("up_wrap_y", 32'(y_topleft), 336);
    press(M_DOWN, 8);
    chk("down_wrap_id", VGAid, 9);
    chk("down_wrap_y", 32'(y_topleft), 112);

    // Navigate to (5,3)
    press(M_RIGHT, 8);
    repeat (5) press(M_RIGHT, 8);
    repeat (3) press(M_DOWN, 8);
    chk("nav_id", VGAid, 35);
    chk("nav_x", 32'(x_topleft), 320);
    chk("nav_y", 32'(y_topleft), 208);

    // Long click with right presses during FLIP and during HOLD
    @(negedge clock);
    model_event(M_CLICK, cyc);
    $display("click held 20 with right during FLIP and HOLD -> expect one flip of id 35");
    btn_click = 1'b1;
    repeat (2) @(negedge clock);
    btn_right = 1'b1;
    repeat (6) @(negedge clock);
    btn_right = 1'b0;
    repeat (2) @(negedge clock);
    btn_right = 1'b1;
    repeat (6) @(negedge clock);
    btn_right = 1'b0;
    repeat (4) @(negedge clock);
    btn_click = 1'b0;
    repeat (30) @(negedge clock);
    chk("click_keeps_id", VGAid, 35);

    press(M_CLICK, 10);
    press(M_UP | M_DOWN, 8);
    chk("up_down_cancel", VGAid, 35);

    do_reset();
    press(M_UP | M_RIGHT, 8);
    chk("diag_id", VGAid, 71);

    // Click one cycle behind a move: flip must see the post-move tile
    @(negedge clock);
    model_event(M_RIGHT, cyc);
    btn_right = 1'b1;
    @(negedge clock);
    model_event(M_CLICK, cyc);
    $display("right then click next cycle -> expect move to id 72 then flip of id 72");
    btn_click = 1'b1;
    repeat (8) @(negedge clock);
    btn_right = 1'b0;
    @(negedge clock);
    btn_click = 1'b0;
    repeat (25) @(negedge clock);

    // Randomised presses
    for (int i = 0; i < 60; i++) begin
      logic [4:0] m;
      int         len;
      m = 5'($urandom_range(0, 31));
      if (m[4] && $urandom_range(0, 1) == 0) m[4] = 1'b0;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB - 1)
                                        : $urandom_range(DB + 2, DB + 10);
      press(m, len);
    end

    // Reset on the second flip cycle
    if (m_col == 0 && m_row == 0) press(M_RIGHT, 8);
    @(negedge clock);
    model_event(M_CLICK, cyc);
    $display("click then reset on 2nd flip cycle");
    btn_click = 1'b1;
    for (int t = 0; t < 40 && !flip; t++) @(negedge clock);
    chk("flip_rise_seen", 32'(flip), 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    btn_click = 1'b0;
    #1;
    chk("midflip_rst_flip", 32'(flip), 0);
    chk("midflip_rst_x", 32'(x_topleft), OX);
    chk("midflip_rst_y", 32'(y_topleft), OY);
    chk("midflip_rst_id", VGAid, 0);
    q.delete();
    m_col = 0;
    m_row = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    press(M_CLICK, 10);

    repeat (30) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
